// File: rtl/bsg_manycore_link_pipe_row.sv
// bsg_manycore_link_pipe_row
//   Multi-channel ready/valid retiming pipeline for the inter-pod link
//   boundaries of a pod row. Each channel gets num_stages_p registered
//   2-entry buffers and runs at full throughput. The upstream ready of each
//   stage comes from that stage's own count register. There is therefore no
//   combinational path from ready_and_i to ready_and_o.
//   Channels selected by tieoff_mask_p are sinks with no storage. They replace
//   the static edge tieoffs.
//
// Ports (c = channel)
//   clk_i, reset_i     clock, synchronous active-high reset
//   v_i/data_i         upstream valid / payload                [c][width_p]
//   ready_and_o        upstream ready (ready-and handshake)    [c]
//   v_o/data_o         downstream valid / payload              [c][width_p]
//   ready_and_i        downstream ready                        [c]
//   quiesce_i          blocks new input on all channels; buffered data drains
//   occupancy_o        words held per channel                  [c][occ_w_lp]
//   idle_o             every non-tied-off channel is empty

// One channel: a chain of num_stages_p 2-entry buffers.
module bsg_manycore_link_pipe_row_chan #(
    parameter int width_p      = 1,
    parameter int num_stages_p = 1,
    parameter int occ_w_p      = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_and_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_and_i,
    input  logic               quiesce_i,
    output logic [occ_w_p-1:0] occupancy_o
);
    // Index k is the link into stage k. Index num_stages_p is the channel output.
    logic [num_stages_p:0]              v_s;
    logic [num_stages_p:0]              r_s;
    logic [num_stages_p:0][width_p-1:0] d_s;
    logic [num_stages_p-1:0][1:0]       cnt_s;

    assign v_s[0]            = v_i & ~quiesce_i & ~reset_i;
    assign d_s[0]            = data_i;
    assign ready_and_o       = r_s[0] & ~quiesce_i & ~reset_i;
    assign r_s[num_stages_p] = ready_and_i;
    assign v_o               = v_s[num_stages_p] & ~reset_i;
    assign data_o            = d_s[num_stages_p];

    for (genvar k = 0; k < num_stages_p; k++) begin : stg
        logic [1:0][width_p-1:0] mem;
        logic                    wr_ptr, rd_ptr;
        logic [1:0]              cnt;
        logic                    enq, deq;

        assign enq        = v_s[k] & r_s[k];
        assign deq        = v_s[k+1] & r_s[k+1];
        // Ready is count<2 taken straight from the register. With two entries
        // this keeps a full-rate stream moving without a bubble.
        assign r_s[k]     = ~cnt[1];
        assign v_s[k+1]   = |cnt;
        // A write only lands in the free slot. The head therefore holds still while stalled.
        assign d_s[k+1]   = mem[rd_ptr];
        assign cnt_s[k]   = cnt;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cnt    <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (enq) begin
                    mem[wr_ptr] <= d_s[k];
                    wr_ptr      <= ~wr_ptr;
                end
                if (deq) rd_ptr <= ~rd_ptr;
                cnt <= cnt + {1'b0, enq} - {1'b0, deq};
            end
        end
    end

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < num_stages_p; k++)
            occupancy_o = occupancy_o + occ_w_p'(cnt_s[k]);
    end

    hold_data_a: assert property (@(posedge clk_i) disable iff (reset_i)
        (v_o & ~ready_and_i) |=> $stable(data_o));
endmodule

module bsg_manycore_link_pipe_row #(
    parameter int                        width_p        = 1,
    parameter int                        num_channels_p = 1,
    parameter int                        num_stages_p   = 1,
    parameter logic [num_channels_p-1:0] tieoff_mask_p  = '0,
    parameter logic [width_p-1:0]        tieoff_val_p   = '0,
    localparam int occ_w_lp = (num_stages_p == 0) ? 1 : $clog2(2*num_stages_p+1)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [num_channels_p-1:0]               v_i,
    input  logic [num_channels_p-1:0][width_p-1:0]  data_i,
    output logic [num_channels_p-1:0]               ready_and_o,
    output logic [num_channels_p-1:0]               v_o,
    output logic [num_channels_p-1:0][width_p-1:0]  data_o,
    input  logic [num_channels_p-1:0]               ready_and_i,
    input  logic                                    quiesce_i,
    output logic [num_channels_p-1:0][occ_w_lp-1:0] occupancy_o,
    output logic                                    idle_o
);
    logic [num_channels_p-1:0] busy;
    // The clock has no load when every channel is tied off or passthrough.
    logic unused_clk;
    assign unused_clk = clk_i;

    for (genvar c = 0; c < num_channels_p; c++) begin : ch
        if (tieoff_mask_p[c]) begin : tie
            // This is a sink that swallows anything sent to it. It ignores quiesce and reset.
            logic unused_tie;
            assign unused_tie     = ^{v_i[c], data_i[c], ready_and_i[c]};
            assign v_o[c]         = 1'b0;
            assign data_o[c]      = tieoff_val_p;
            assign ready_and_o[c] = 1'b1;
            assign occupancy_o[c] = '0;
            assign busy[c]        = 1'b0;
        end else if (num_stages_p == 0) begin : thru
            assign v_o[c]         = v_i[c];
            assign data_o[c]      = data_i[c];
            assign ready_and_o[c] = ready_and_i[c] & ~quiesce_i;
            assign occupancy_o[c] = '0;
            assign busy[c]        = 1'b0;
        end else begin : pipe
            bsg_manycore_link_pipe_row_chan #(
                .width_p     (width_p),
                .num_stages_p(num_stages_p),
                .occ_w_p     (occ_w_lp)
            ) u_chan (
                .clk_i      (clk_i),
                .reset_i    (reset_i),
                .v_i        (v_i[c]),
                .data_i     (data_i[c]),
                .ready_and_o(ready_and_o[c]),
                .v_o        (v_o[c]),
                .data_o     (data_o[c]),
                .ready_and_i(ready_and_i[c]),
                .quiesce_i  (quiesce_i),
                .occupancy_o(occupancy_o[c])
            );
            assign busy[c] = |occupancy_o[c];
        end
    end

    assign idle_o = reset_i | ~|busy;
endmodule

// File: tb/tb_bsg_manycore_link_pipe_row.sv
// Bench for bsg_manycore_link_pipe_row. It builds three configurations:
//   dut_a: 3 stages, 2 channels
//   dut_b: 2 stages, channel 1 tied off to 16'hFFFF
//   dut_z: 0 stages (passthrough)
// A reference model for each channel keeps a queue of accepted words and
// their accept cycles. It checks order, data, latency bounds and occupancy
// every cycle.
module tb_bsg_manycore_link_pipe_row;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst   [2];
    logic             qui   [2];
    logic             idle  [2];
    logic [1:0]       v_i   [2];
    logic [1:0]       rdy_o [2];
    logic [1:0]       v_o   [2];
    logic [1:0]       rdy_i [2];
    logic [1:0][15:0] d_i   [2];
    logic [1:0][15:0] d_o   [2];
    logic [1:0][2:0]  occ   [2];

    logic             zrst, zq, zidle;
    logic [1:0]       zv, zr, zv_o, zr_o;
    logic [1:0][15:0] zd, zd_o;
    logic [1:0][0:0]  zocc;

    bsg_manycore_link_pipe_row #(.width_p(16), .num_channels_p(2), .num_stages_p(3)) dut_a (
        .clk_i(clk), .reset_i(rst[0]), .v_i(v_i[0]), .data_i(d_i[0]), .ready_and_o(rdy_o[0]),
        .v_o(v_o[0]), .data_o(d_o[0]), .ready_and_i(rdy_i[0]), .quiesce_i(qui[0]),
        .occupancy_o(occ[0]), .idle_o(idle[0]));

    bsg_manycore_link_pipe_row #(.width_p(16), .num_channels_p(2), .num_stages_p(2),
        .tieoff_mask_p(2'b10), .tieoff_val_p(16'hFFFF)) dut_b (
        .clk_i(clk), .reset_i(rst[1]), .v_i(v_i[1]), .data_i(d_i[1]), .ready_and_o(rdy_o[1]),
        .v_o(v_o[1]), .data_o(d_o[1]), .ready_and_i(rdy_i[1]), .quiesce_i(qui[1]),
        .occupancy_o(occ[1]), .idle_o(idle[1]));

    bsg_manycore_link_pipe_row #(.width_p(16), .num_channels_p(2), .num_stages_p(0)) dut_z (
        .clk_i(clk), .reset_i(zrst), .v_i(zv), .data_i(zd), .ready_and_o(zr_o),
        .v_o(zv_o), .data_o(zd_o), .ready_and_i(zr), .quiesce_i(zq),
        .occupancy_o(zocc), .idle_o(zidle));

    // reference model
    logic [15:0] mq [2][2][$];
    int          ma [2][2][$];
    int          s_of [2] = '{3, 2};
    int          n_in [2][2];
    int          n_out[2][2];
    logic [15:0] nxt  [2][2];
    bit          prev_stall [2][2];
    bit          chk_lat;
    int          cyc_n;
    int          n_cmp, n_bad;
    int          b_in, b_out;
    int          b2 [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int d, input int c, input bit v);
        v_i[d][c] = v;
        d_i[d][c] = nxt[d][c];
    endtask

    task automatic mon(input int d);
        bit all_empty = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (d == 1 && c == 1) begin
                chk("tie_v", 32'(v_o[1][1]), 0);
                chk("tie_data", 32'(d_o[1][1]), 32'h0000FFFF);
                chk("tie_rdy", 32'(rdy_o[1][1]), 1);
                chk("tie_occ", 32'(occ[1][1]), 0);
                continue;
            end
            if (rst[d]) begin
                chk($sformatf("rst_v d%0d c%0d", d, c), 32'(v_o[d][c]), 0);
                chk($sformatf("rst_rdy d%0d c%0d", d, c), 32'(rdy_o[d][c]), 0);
                mq[d][c].delete();
                ma[d][c].delete();
                prev_stall[d][c] = 1'b0;
                continue;
            end
            chk($sformatf("occ d%0d c%0d", d, c), 32'(occ[d][c]), mq[d][c].size());
            if (mq[d][c].size() != 0) all_empty = 1'b0;
            if (prev_stall[d][c]) chk($sformatf("hold_v d%0d c%0d", d, c), 32'(v_o[d][c]), 1);
            if (mq[d][c].size() == 0) chk($sformatf("v_empty d%0d c%0d", d, c), 32'(v_o[d][c]), 0);
            if (mq[d][c].size() == 2*s_of[d])
                chk($sformatf("full_rdy d%0d c%0d", d, c), 32'(rdy_o[d][c]), 0);
            if (qui[d]) chk($sformatf("q_rdy d%0d c%0d", d, c), 32'(rdy_o[d][c]), 0);
            if (v_o[d][c] && mq[d][c].size() != 0) begin
                chk($sformatf("data d%0d c%0d", d, c), 32'(d_o[d][c]), 32'(mq[d][c][0]));
                chk($sformatf("lat_min d%0d c%0d", d, c), 32'(cyc_n - ma[d][c][0] >= s_of[d]), 1);
                if (rdy_i[d][c]) begin
                    if (chk_lat) chk($sformatf("lat d%0d c%0d", d, c), cyc_n - ma[d][c][0], s_of[d]);
                    void'(mq[d][c].pop_front());
                    void'(ma[d][c].pop_front());
                    n_out[d][c]++;
                end
            end
            prev_stall[d][c] = v_o[d][c] & ~rdy_i[d][c];
            if (v_i[d][c] && rdy_o[d][c]) begin
                mq[d][c].push_back(d_i[d][c]);
                ma[d][c].push_back(cyc_n);
                n_in[d][c]++;
                nxt[d][c] = nxt[d][c] + 16'd1;
            end
        end
        if (rst[d]) chk($sformatf("rst_idle d%0d", d), 32'(idle[d]), 1);
        else        chk($sformatf("idle d%0d", d), 32'(idle[d]), 32'(all_empty));
    endtask

    task automatic step();
        @(negedge clk);
        mon(0);
        mon(1);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc_n = 0; chk_lat = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; qui[d] = 1'b0; v_i[d] = '0; rdy_i[d] = '0; d_i[d] = '0;
            for (int c = 0; c < 2; c++) begin
                nxt[d][c] = '0; n_in[d][c] = 0; n_out[d][c] = 0; prev_stall[d][c] = 1'b0;
            end
        end
        zrst = 1'b0; zq = 1'b0; zv = '0; zr = '0; zd = '0;

        // passthrough configuration
        for (int i = 0; i < 24; i++) begin
            zv = 2'($urandom); zr = 2'($urandom); zq = ($urandom_range(3, 0) == 0);
            zd = {16'($urandom), 16'($urandom)};
            #1;
            chk("z_v", 32'(zv_o), 32'(zv));
            chk("z_data", 32'(zd_o), 32'(zd));
            chk("z_rdy", 32'(zr_o), 32'(zr & {2{~zq}}));
            chk("z_occ", 32'(zocc), 0);
            chk("z_idle", 32'(zidle), 1);
            #4;
        end

        // reset state
        @(posedge clk); #1;
        repeat (2) step();
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        chk("post_rst_rdy_a", 32'(rdy_o[0]), 32'h3);
        chk("post_rst_rdy_b", 32'(rdy_o[1]), 32'h3);

        // streaming: latency exactly S, no gaps
        rdy_i[0] = 2'b11; rdy_i[1] = 2'b11; chk_lat = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 1'b1); drive(1, 0, 1'b1);
            step();
        end
        drive(0, 0, 1'b0); drive(1, 0, 1'b0);
        repeat (6) step();
        chk_lat = 1'b0;
        chk("t1_out_a", n_out[0][0], 100);
        chk("t1_out_b", n_out[1][0], 100);

        // stalled ch0 fills to 2*S, ch1 keeps moving
        rdy_i[0] = 2'b10; rdy_i[1] = 2'b10;
        b2[0] = n_in[0][0]; b2[1] = n_in[1][0];
        for (int i = 0; i < 7; i++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, 0, i < 2*s_of[d] + 1);
                drive(d, 1, 1'($urandom));
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            drive(d, 0, 1'b0); drive(d, 1, 1'b0);
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t2_acc d%0d", d), n_in[d][0] - b2[d], 2*s_of[d]);
            chk($sformatf("t2_occ d%0d", d), 32'(occ[d][0]), 2*s_of[d]);
            chk($sformatf("t2_rdy d%0d", d), 32'(rdy_o[d][0]), 0);
        end
        rdy_i[0] = 2'b11; rdy_i[1] = 2'b11;
        repeat (12) step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t2_drain_occ d%0d", d), 32'(occ[d][0]), 0);
            chk($sformatf("t2_drain_cnt d%0d", d), n_out[d][0], n_in[d][0]);
        end

        // random traffic
        for (int i = 0; i < 20000; i++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, 0, 1'($urandom)); drive(d, 1, 1'($urandom));
                rdy_i[d] = 2'($urandom);
                qui[d] = ($urandom_range(15, 0) == 0);
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            drive(d, 0, 1'b0); drive(d, 1, 1'b0); rdy_i[d] = 2'b11; qui[d] = 1'b0;
        end
        repeat (20) step();
        chk("t3_drain_a0", n_out[0][0], n_in[0][0]);
        chk("t3_drain_a1", n_out[0][1], n_in[0][1]);
        chk("t3_drain_b0", n_out[1][0], n_in[1][0]);
        chk("t3_idle_a", 32'(idle[0]), 1);
        chk("t3_idle_b", 32'(idle[1]), 1);

        // quiesce with 3 words buffered
        rdy_i[0] = 2'b10;
        b_in = n_in[0][0]; b_out = n_out[0][0];
        repeat (3) begin drive(0, 0, 1'b1); step(); end
        qui[0] = 1'b1; rdy_i[0] = 2'b11; drive(0, 0, 1'b1);
        #1;
        chk("t5_q_rdy", 32'(rdy_o[0]), 0);
        repeat (6) step();
        chk("t5_in", n_in[0][0] - b_in, 3);
        chk("t5_out", n_out[0][0] - b_out, 3);
        chk("t5_idle", 32'(idle[0]), 1);
        qui[0] = 1'b0; drive(0, 0, 1'b0);
        step();

        // reset mid-stream with occupancy 4
        rdy_i[0] = 2'b10;
        b_out = n_out[0][0];
        repeat (4) begin drive(0, 0, 1'b1); step(); end
        chk("t6_occ4", 32'(occ[0][0]), 4);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        #1;
        chk("t6_occ0", 32'(occ[0][0]), 0);
        chk("t6_rdy", 32'(rdy_o[0]), 32'h3);
        chk("t6_v", 32'(v_o[0]), 0);
        drive(0, 0, 1'b0); rdy_i[0] = 2'b11;
        repeat (8) step();
        chk("t6_no_out", n_out[0][0] - b_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
